// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// port-select encoding and the default word-address width.
package dm_arb_pkg;

    localparam int DM_ARB_AW = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_MERGE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_t;

endpackage

// File: rtl/dm_merge.sv
// Combinational lane merge for sub-word stores: replaces one byte or one
// halfword of the old memory word with the low bits of the store data.
module dm_merge
    import dm_arb_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr,
    input  logic        sh,
    input  logic        sb,
    output logic [31:0] merged
);

    // Only the low halfword of the store data can ever reach memory.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:16];

    always_comb begin
        merged = old_word;
        if (sb) begin
            case (addr)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (sh) begin
            if (addr[1]) begin
                merged[31:16] = wdata[15:0];
            end else begin
                merged[15:0] = wdata[15:0];
            end
        end
    end

endmodule

// File: rtl/dm_arb.sv
// dm_arb: CPU / debug arbiter in front of a word-only data memory, with
// read-modify-write for byte and halfword stores. Debug port enabled by DM_ARB_DBG_EN.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int AW = DM_ARB_AW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_sh,
    input  logic          cpu_sb,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_sh,
    input  logic          dbg_sb,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic [1:0]    fsm_state
);

    // Handshake: a requester raises req with we/sh/sb/addr/wdata stable and
    // holds them until its ack; ack is a one-cycle completion pulse with rdata
    // valid in that cycle; req drops in the cycle after ack.

    state_t      state;
    port_t       gnt_q;
    logic        any_req;
    logic        s_we;
    logic        s_sh;
    logic        s_sb;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    logic        we_q;
    logic        sh_q;
    logic        sb_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic        mem_we_q;
    logic        sub_q;
    logic        go_done;
    logic        rd_cap;

    logic unused_addr_hi;
    assign unused_addr_hi = ^s_addr[31:AW+2];

`ifdef DM_ARB_DBG_EN
    port_t sel;

    // Round robin: on a tie the port not granted last wins.
    always_comb begin
        sel = PORT_CPU;
        if (dbg_req && (!cpu_req || gnt_q == PORT_CPU)) begin
            sel = PORT_DBG;
        end
    end

    assign any_req = cpu_req | dbg_req;

    always_comb begin
        if (sel == PORT_DBG) begin
            {s_we, s_sh, s_sb, s_addr, s_wdata} = {dbg_we, dbg_sh, dbg_sb, dbg_addr, dbg_wdata};
        end else begin
            {s_we, s_sh, s_sb, s_addr, s_wdata} = {cpu_we, cpu_sh, cpu_sb, cpu_addr, cpu_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= PORT_DBG;
        end else if (state == ST_IDLE && any_req) begin
            gnt_q <= sel;
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_req, dbg_we, dbg_sh, dbg_sb, dbg_addr, dbg_wdata};

    assign gnt_q   = PORT_CPU;
    assign any_req = cpu_req;
    assign s_we    = cpu_we;
    assign s_sh    = cpu_sh;
    assign s_sb    = cpu_sb;
    assign s_addr  = cpu_addr;
    assign s_wdata = cpu_wdata;
`endif

    assign sub_q = we_q & (sh_q | sb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_we_q <= 1'b0;
            mem_addr <= '0;
            we_q     <= 1'b0;
            sh_q     <= 1'b0;
            sb_q     <= 1'b0;
            lane_q   <= 2'd0;
            wdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        we_q     <= s_we;
                        sh_q     <= s_sh;
                        sb_q     <= s_sb;
                        lane_q   <= s_addr[1:0];
                        wdata_q  <= s_wdata;
                        mem_addr <= s_addr[AW+1:2];
                        mem_we_q <= s_we & ~(s_sh | s_sb);
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (sub_q) begin
                        merge_q  <= mem_rdata;
                        mem_we_q <= 1'b1;
                        state    <= ST_MERGE;
                    end else begin
                        mem_we_q <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_MERGE: begin
                    mem_we_q <= 1'b0;
                    state    <= ST_DONE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    dm_merge u_merge (
        .old_word (merge_q),
        .wdata    (wdata_q),
        .addr     (lane_q),
        .sh       (sh_q),
        .sb       (sb_q),
        .merged   (merged)
    );

    // Gating with rst kills a write already in flight in the reset cycle itself.
    assign mem_we    = mem_we_q & ~rst;
    assign mem_wdata = (state == ST_MERGE) ? merged : wdata_q;
    assign fsm_state = state;

    assign go_done = (state == ST_MERGE) || (state == ST_ACC && !sub_q);
    assign rd_cap  = (state == ST_ACC) && !we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= go_done && (gnt_q == PORT_CPU);
            if (rd_cap && gnt_q == PORT_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

`ifdef DM_ARB_DBG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= go_done && (gnt_q == PORT_DBG);
            if (rd_cap && gnt_q == PORT_DBG) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end
`else
    assign dbg_ack   = 1'b0;
    assign dbg_rdata = '0;
`endif

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb: directed vectors, reset/arbitration corner
// cases and randomized traffic against a word-array reference model.
module tb_dm_arb;
  import dm_arb_pkg::*;

  localparam int AW    = 7;
  localparam int NWORD = 1 << AW;
  localparam int NV    = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_sh, cpu_sb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_sh, dbg_sb;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  fsm_state;

  dm_arb #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sh(cpu_sh), .cpu_sb(cpu_sb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sh(dbg_sh), .dbg_sb(dbg_sb),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // Memory the DUT talks to; ref_mem is the bench's own model of its contents.
  logic [31:0] mem [NWORD] = '{default: 32'h0};
  logic [31:0] ref_mem [NWORD] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd [2];

  typedef struct {
    logic        we, sh, sb;
    logic [31:0] addr, wdata;
    logic [31:0] exp_word, exp_rd;
  } vec_t;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [31:0] addr, input logic sh, input logic sb);
    int sft;
    logic [31:0] mask;
    if (sb) begin
      sft = 8 * int'(addr[1:0]);
      mask = 32'hFF << sft;
      return (old & ~mask) | ((wd & 32'hFF) << sft);
    end
    if (sh) begin
      sft = 16 * int'(addr[1]);
      mask = 32'hFFFF << sft;
      return (old & ~mask) | ((wd & 32'hFFFF) << sft);
    end
    return wd;
  endfunction

  task automatic drive(input bit p, input logic req, input logic we, input logic sh, input logic sb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      dbg_req = req; dbg_we = we; dbg_sh = sh; dbg_sb = sb; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_sh = sh; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  // One complete transaction on port p, checked against the reference model.
  task automatic txn(input bit p, input logic we, input logic sh, input logic sb,
                     input logic [31:0] addr, input logic [31:0] wdata, input string name,
                     output logic [31:0] rd);
    int lat, we_cnt, other_ack, widx, exp_lat;
    logic [AW-1:0] we_addr;
    logic [1:0] we_state;
    logic sub;
    sub = we && (sh || sb);
    exp_lat = sub ? 3 : 2;
    widx = int'(addr[AW+1:2]);
    lat = 0; we_cnt = 0; other_ack = 0; we_addr = '0; we_state = 2'd0;
    @(negedge clk);
    drive(p, 1'b1, we, sh, sb, addr, wdata);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_state = fsm_state;
      end
      if (p ? cpu_ack : dbg_ack) other_ack++;
      if (p ? dbg_ack : cpu_ack) begin
        lat = c;
        break;
      end
    end
    rd = p ? dbg_rdata : cpu_rdata;
    drive(p, 1'b0, we, sh, sb, addr, wdata);
    @(posedge clk);
    #1;
    check({name, "_ack_width"}, {31'b0, p ? dbg_ack : cpu_ack}, 32'h0);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_other_ack"}, other_ack, 0);
    check({name, "_we_count"}, we_cnt, we ? 1 : 0);
    if (we) begin
      check({name, "_we_addr"}, {{(32-AW){1'b0}}, we_addr}, widx);
      check({name, "_we_state"}, {30'b0, we_state}, sub ? 32'(ST_MERGE) : 32'(ST_ACC));
      check({name, "_rdata_hold"}, rd, last_rd[p]);
      ref_mem[widx] = ref_store(ref_mem[widx], wdata, addr, sh, sb);
    end else begin
      exp_q.push_back(ref_mem[widx]);
      check({name, "_rdata"}, rd, exp_q.pop_front());
      last_rd[p] = rd;
    end
    check({name, "_mem_word"}, mem[widx], ref_mem[widx]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int widx, bad, got, prev_c, prev_d, both, longp;
    bit p;
    logic we, sh, sb;
    logic [31:0] addr;

    vecs[0]  = '{1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 0, 1, 32'h0000_0012, 32'h0000_0055, 32'hDE55_BEEF, 32'h0};
    vecs[3]  = '{1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{1, 1, 0, 32'h0000_0012, 32'h0000_1234, 32'h1234_BEEF, 32'h0};
    vecs[5]  = '{1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{1, 1, 0, 32'h0000_0011, 32'h0000_1234, 32'hDEAD_1234, 32'h0};
    vecs[7]  = '{1, 1, 1, 32'h0000_0013, 32'h0000_00AA, 32'hAAAD_1234, 32'h0};
    vecs[8]  = '{0, 1, 1, 32'h0000_0010, 32'h0,         32'hAAAD_1234, 32'hAAAD_1234};
    vecs[9]  = '{1, 0, 1, 32'h0000_0010, 32'hFFFF_FF77, 32'hAAAD_1277, 32'h0};
    vecs[10] = '{1, 0, 0, 32'hFFFF_F1FC, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0};
    vecs[11] = '{0, 0, 0, 32'h0000_01FC, 32'h0,         32'h0BAD_F00D, 32'h0BAD_F00D};
    vecs[12] = '{1, 1, 0, 32'h0000_001E, 32'hABCD_5678, 32'h5678_0000, 32'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();

    check("rst_state", {30'b0, fsm_state}, 32'(ST_IDLE));
    check("rst_cpu_ack", {31'b0, cpu_ack}, 32'h0);
    check("rst_dbg_ack", {31'b0, dbg_ack}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      txn(1'b0, vecs[i].we, vecs[i].sh, vecs[i].sb, vecs[i].addr, vecs[i].wdata,
          $sformatf("vec%0d", i), rd);
      widx = int'(vecs[i].addr[AW+1:2]);
      check($sformatf("vec%0d_table_word", i), mem[widx], vecs[i].exp_word);
      if (!vecs[i].we) check($sformatf("vec%0d_table_rdata", i), rd, vecs[i].exp_rd);
    end

    // Reset while the sub-word write sits in MERGE: the write must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0099);
    @(posedge clk); #1;
    check("rstm_acc", {30'b0, fsm_state}, 32'(ST_ACC));
    @(posedge clk); #1;
    check("rstm_merge", {30'b0, fsm_state}, 32'(ST_MERGE));
    rst = 1'b1;
    #1;
    check("rstm_we_now", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    check("rstm_we_next", {31'b0, mem_we}, 32'h0);
    check("rstm_idle", {30'b0, fsm_state}, 32'(ST_IDLE));
    check("rstm_ack", {31'b0, cpu_ack}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ack || dbg_ack || mem_we) bad++;
    end
    check("rstm_quiet", bad, 0);
    check("rstm_word", mem[4], ref_mem[4]);

`ifdef DM_ARB_DBG_EN
    // Both ports hold req continuously from reset: grants must alternate.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
    got = 0; prev_c = 0; prev_d = 0; both = 0; longp = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (cpu_ack && dbg_ack) both++;
      if ((cpu_ack && prev_c != 0) || (dbg_ack && prev_d != 0)) longp++;
      if ((cpu_ack || dbg_ack) && exp_q.size() > 0) begin
        check($sformatf("rr_grant%0d", got), {31'b0, dbg_ack}, exp_q.pop_front());
        got++;
      end
      prev_c = int'(cpu_ack);
      prev_d = int'(dbg_ack);
      if (got == 4) break;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rr_count", got, 4);
    check("rr_both", both, 0);
    check("rr_long", longp, 0);
    check("rr_cpu_rdata", cpu_rdata, ref_mem[4]);
    check("rr_dbg_rdata", dbg_rdata, ref_mem[8]);
    last_rd[0] = cpu_rdata;
    last_rd[1] = dbg_rdata;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ack || dbg_ack) bad++;
    end
    check("rr_no_extra_ack", bad, 0);
`else
    // Debug port is absent: a held dbg request must never reach memory.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1234_5678);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dbg_ack || mem_we || fsm_state != ST_IDLE) bad++;
    end
    check("nodbg_quiet", bad, 0);
    check("nodbg_word", mem[4], ref_mem[4]);
    check("nodbg_rdata", dbg_rdata, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
`ifdef DM_ARB_DBG_EN
      p = 1'($urandom_range(0, 1));
`else
      p = 1'b0;
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
`endif
      we = 1'($urandom_range(0, 1));
      sh = ($urandom_range(0, 2) == 0);
      sb = ($urandom_range(0, 2) == 0);
      addr = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 31));
      txn(p, we, sh, sb, addr, $urandom, $sformatf("rnd%0d", i), rd);
    end
`ifndef DM_ARB_DBG_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("nodbg_rdata_end", dbg_rdata, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 SHALL have parameter AW, default 7: word-address width presented to the data memory (byte addr[AW+1:2]).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_sh in 1, cpu_sb in 1, cpu_addr in 32 (byte address), cpu_wdata in 32: CPU request.
REQ-005 SHALL have ports cpu_ack out 1 and cpu_rdata out 32: CPU completion and read data.
REQ-006 SHALL have ports dbg_req, dbg_we, dbg_sh, dbg_sb, dbg_addr, dbg_wdata, dbg_ack and dbg_rdata, with the same widths, directions and meanings as the CPU set: debug/loader port.
REQ-007 SHALL have ports mem_we out 1, mem_addr out AW, mem_wdata out 32 and mem_rdata in 32: word-only memory port; mem_rdata is combinational from mem_addr.

Function
REQ-008 SHALL implement FSM states IDLE, ACC, MERGE and DONE.
REQ-009 SHALL, in IDLE with any req high, grant one requester, latch its we/sh/sb/addr/wdata and go to ACC.
REQ-010 SHALL arbitrate round-robin: if both request, the port not granted last wins; a single requester always wins.
REQ-011 SHALL, in ACC, drive mem_addr = latched addr[AW+1:2].
- Read: capture mem_rdata into the read register, then go to DONE.
- Word write: mem_we=1, mem_wdata=latched wdata, then go to DONE.
- Sub-word write: capture mem_rdata into the merge register, mem_we=0, then go to MERGE.
REQ-012 SHALL, in MERGE, drive mem_we=1 and mem_wdata=merged word, then go to DONE.
- Byte: lane addr[1:0] replaced by wdata[7:0].
- Half: lane addr[1] (1 = bits [31:16]) replaced by wdata[15:0].
REQ-013 SHALL treat sb=1 as byte, regardless of sh; sh/sb SHALL be ignored on reads; addr[0] SHALL be ignored for halfwords.
REQ-014 SHALL, in DONE, pulse the granted port's ack for exactly one cycle, with rdata valid in that cycle, then return to IDLE.
REQ-015 SHALL hold rdata until the next read completes on that port.
REQ-016 SHALL have latency from req sampled in IDLE to ack of 2 cycles for reads and word writes, and 3 cycles for sub-word writes.
REQ-017 SHALL rely on requesters holding req and all fields stable until ack, and dropping req in the cycle after ack; req high in IDLE after DONE is a new request.
REQ-018 SHALL drive mem_we=1 only in ACC (word write) and MERGE; mem_we SHALL be 0 in all other states.
REQ-019 SHALL ignore req changes while not in IDLE; a requester never receives an ack it did not request.

Reset
REQ-020 SHALL, on rst at a clock edge, set state=IDLE, last-grant=dbg (CPU wins the first tie), cpu_ack=dbg_ack=0, both rdata=0, mem_we=0 and mem_addr=0.
REQ-021 SHALL abort any in-flight access when rst is asserted mid-operation (ACC or MERGE): no further mem_we and no ack.

Configuration
REQ-022 SHALL, with DM_ARB_DBG_EN defined, provide the full two-port arbitration described above.
REQ-023 SHALL, without DM_ARB_DBG_EN, ignore dbg inputs, tie dbg_ack=0 and dbg_rdata=0, always grant the CPU and remove the round-robin state.

Structure
REQ-024 SHALL place the FSM state enum, the port-select encoding and the AW default constant in package dm_arb_pkg.
REQ-025 SHALL implement the byte/half lane merge as combinational sub-module dm_merge (inputs: old word, wdata, addr[1:0], sh, sb; output: merged word).

Verification
REQ-026 SHALL cover a CPU word write: addr 0x10, wdata 0xDEADBEEF -> mem_we in ACC with mem_addr=4, ack 2 cycles after req; a following read returns 0xDEADBEEF.
REQ-027 SHALL cover a CPU byte write: word 4 holds 0xDEADBEEF; sb, addr 0x12, wdata 0x55 -> MERGE writes 0xDE55BEEF, ack 3 cycles after req.
REQ-028 SHALL cover a CPU half write: sh, addr 0x12, wdata 0x1234 -> 0x1234BEEF; sh at addr 0x11 -> 0xDEAD1234.
REQ-029 SHALL cover simultaneous requests, both held continuously after reset -> grants alternate cpu, dbg, cpu, dbg; each ack is a single cycle on the correct port only.
REQ-030 SHALL cover rst asserted in MERGE -> no mem_we on the next cycle, no ack, state IDLE; memory word unchanged.
REQ-031 SHALL cover a build without DM_ARB_DBG_EN: dbg_req held high with cpu idle -> dbg_ack stays 0 and mem_we stays 0.
